// File: rtl/mult_seq_controller.sv
// Sequencing FSM for a shift-and-add multiplier datapath.
// The controller holds no operand data: it issues one-cycle load/clear/add/shift
// enables, tracks how many shifts have been done, and looks only at the
// multiplier LSB (q0) fed back from the datapath.
module mult_seq_controller #(
  parameter int N  = 16,  // operand width = number of add/shift iterations
  parameter int CW = 5    // iteration counter width, 2**CW > N
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          q0,
  output logic          ld_operands,
  output logic          clr_acc,
  output logic          add_en,
  output logic          shift_en,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TEST,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_t;

  // Pre-increment count value seen in the final SHIFT of an operation.
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;

  // State and iteration-counter registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state and counter update; start is only looked at in IDLE, q0 only in TEST.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        count_d = '0;
        state_d = S_TEST;
      end
      S_TEST: begin
        state_d = q0 ? S_ADD : S_SHIFT;
      end
      S_ADD: begin
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        count_d = count_q + CW'(1);
        state_d = (count_q == LAST_CNT) ? S_DONE : S_TEST;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore output decode: every output depends on the registered state only.
  always_comb begin
    ld_operands = 1'b0;
    clr_acc     = 1'b0;
    add_en      = 1'b0;
    shift_en    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_LOAD: begin
        ld_operands = 1'b1;
        clr_acc     = 1'b1;
        busy        = 1'b1;
      end
      S_TEST: begin
        busy = 1'b1;
      end
      S_ADD: begin
        add_en = 1'b1;
        busy   = 1'b1;
      end
      S_SHIFT: begin
        shift_en = 1'b1;
        busy     = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
        busy = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign count = count_q;

endmodule

// File: tb/tb_mult_seq_controller.sv
// Directed and randomized bench for mult_seq_controller with a small
// shift-and-add datapath model closing the q0 feedback loop.
module tb_mult_seq_controller;

  localparam int N  = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          q0;
  logic          ld_operands, clr_acc, add_en, shift_en, busy, done;
  logic [CW-1:0] count;

  mult_seq_controller #(.N(N), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .q0         (q0),
    .ld_operands(ld_operands),
    .clr_acc    (clr_acc),
    .add_en     (add_en),
    .shift_en   (shift_en),
    .busy       (busy),
    .done       (done),
    .count      (count)
  );

  always #5 clk = ~clk;

  // Datapath model: multiplicand, accumulator with carry bit, multiplier shift register.
  logic [N-1:0] op_a, op_b;
  logic [N-1:0] mcand, mplier;
  logic [N:0]   acc;

  always @(posedge clk) begin
    if (ld_operands) begin
      mcand  <= op_a;
      mplier <= op_b;
    end
    if (clr_acc) begin
      acc <= '0;
    end else if (add_en) begin
      acc <= {1'b0, acc[N-1:0]} + {1'b0, mcand};
    end else if (shift_en) begin
      acc    <= {1'b0, acc[N:1]};
      mplier <= {acc[0], mplier[N-1:1]};
    end
  end

  assign q0 = mplier[0];

  int n_vec  = 0;
  int n_miss = 0;
  int viol   = 0;
  int done_total = 0;
  int ops_expected = 0;

  // Per-cycle invariant monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if ((int'(ld_operands) + int'(add_en) + int'(shift_en)) > 1) viol++;
      if (clr_acc && !ld_operands) viol++;
      if (done && !busy) viol++;
      if (done && (count != CW'(N))) viol++;
      if (done) done_total++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // mode 0: plain op; mode 1: start pulses in TEST and DONE; mode 2: start held high.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input int exp_cyc,
                        input int exp_adds, input logic [2*N-1:0] exp_prod, input int mode);
    int          cyc, adds, shifts, viol0, cyc2;
    bit          got, got2, load_ok, idle_ok;
    logic [CW-1:0] cnt_test, cnt_done;
    logic [2*N-1:0] prod;
    op_a  = a;
    op_b  = b;
    viol0 = viol;
    cyc = 0; adds = 0; shifts = 0; got = 0; load_ok = 0;
    cnt_test = '0; cnt_done = '0; prod = '0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    ops_expected++;
    while (cyc < 200 && !got) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        if (mode != 2) start = 1'b0;
        load_ok = ld_operands && clr_acc && busy;
      end
      if (cyc == 2) begin
        cnt_test = count;
        if (mode == 1) start = 1'b1;
      end
      if (cyc == 3 && mode == 1) start = 1'b0;
      if (add_en) adds++;
      if (shift_en) shifts++;
      if (done) begin
        got      = 1'b1;
        cnt_done = count;
        prod     = {acc[N-1:0], mplier};
      end
    end
    check("done_seen", 64'(got), 64'd1);
    if (got) begin
      check("load_cycle1", 64'(load_ok), 64'd1);
      check("count_in_test", 64'(cnt_test), 64'd0);
      check("done_cycle", 64'(cyc), 64'(exp_cyc));
      check("add_pulses", 64'(adds), 64'(exp_adds));
      check("shift_pulses", 64'(shifts), 64'(N));
      check("count_at_done", 64'(cnt_done), 64'(N));
      check("product", 64'(prod), 64'(exp_prod));
      if (mode == 1) start = 1'b1;
      @(negedge clk);
      if (mode == 1) start = 1'b0;
      check("idle_after_done",
            64'({busy, done, ld_operands, clr_acc, add_en, shift_en}), 64'd0);
      check("count_held_idle", 64'(count), 64'(N));
      if (mode == 1) begin
        idle_ok = 1'b1;
        repeat (4) begin
          @(negedge clk);
          if (busy || done || ld_operands) idle_ok = 1'b0;
        end
        check("start_ignored_no_requeue", 64'(idle_ok), 64'd1);
      end
      if (mode == 2) begin
        @(negedge clk);
        check("b2b_load", 64'({ld_operands, clr_acc, busy}), 64'b111);
        start = 1'b0;
        ops_expected++;
        cyc2 = 1; got2 = 1'b0;
        while (cyc2 < 200 && !got2) begin
          @(negedge clk);
          cyc2++;
          if (done) got2 = 1'b1;
        end
        check("b2b_done_cycle", 64'(cyc2), 64'(exp_cyc));
        @(negedge clk);
      end
    end
    check("invariants", 64'(viol - viol0), 64'd0);
  endtask

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    int             cyc;
    int             adds;
    logic [2*N-1:0] prod;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int saw_add;
    logic [N-1:0] ra, rb;

    vecs[0] = '{16'h0003, 16'h0000, 34,  0, 32'h0000_0000};
    vecs[1] = '{16'h0003, 16'hFFFF, 50, 16, 32'h0002_FFFD};
    vecs[2] = '{16'h0003, 16'h0005, 36,  2, 32'h0000_000F};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 50, 16, 32'hFFFE_0001};
    vecs[4] = '{16'h1234, 16'h8001, 36,  2, 32'h091A_1234};
    vecs[5] = '{16'hABCD, 16'h00F0, 38,  4, 32'h00A1_1030};

    reset = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_outputs",
          64'({busy, done, ld_operands, clr_acc, add_en, shift_en}), 64'd0);
    check("reset_count", 64'(count), 64'd0);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cyc, vecs[i].adds, vecs[i].prod, 0);
    end

    // Reset in the middle of an ADD cycle.
    op_a = 16'h0003;
    op_b = 16'hFFFF;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    saw_add = 0;
    for (int k = 0; k < 50 && saw_add == 0; k++) begin
      @(negedge clk);
      if (add_en) saw_add = 1;
    end
    check("reached_add", 64'(saw_add), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midop_reset_outputs",
          64'({busy, done, ld_operands, clr_acc, add_en, shift_en}), 64'd0);
    check("midop_reset_count", 64'(count), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_idle", 64'({busy, done, count}), 64'd0);

    // start pulsed in TEST and in DONE, then start held high.
    run_op(16'h0007, 16'h0009, 36, 2, 32'h0000_003F, 1);
    run_op(16'h0002, 16'h0003, 36, 2, 32'h0000_0006, 2);

    // Random multipliers.
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      run_op(ra, rb, 34 + $countones(rb), $countones(rb), 32'(ra) * 32'(rb), 0);
    end

    repeat (2) @(negedge clk);
    check("total_done_pulses", 64'(done_total), 64'(ops_expected));
    check("total_violations", 64'(viol), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mult_seq_controller.md
Name: mult_seq_controller

Overview:
Control FSM that sequences a shift-and-add multiplier datapath built from n_bit_register-style storage: operand registers, accumulator and shift register. It accepts a start pulse and issues one-cycle load, clear, add and shift enables. It keeps the iteration count and signals busy/done. It holds no operand data itself; the datapath feeds back only the current multiplier LSB.

Parameters:
N, 16, operand width in bits; number of add/shift iterations per multiply (N >= 2)
CW, 5, iteration counter width; must satisfy 2^CW > N

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a new multiply; sampled only in IDLE
q0  input  1  current LSB of the datapath multiplier shift register
ld_operands  output  1  load multiplicand/multiplier registers from operand bus
clr_acc  output  1  clear accumulator to 0
add_en  output  1  accumulator <= accumulator + multiplicand
shift_en  output  1  shift {accumulator, multiplier} right by one
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse; product valid in datapath
count  output  CW  number of shifts completed in current operation

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high; the clock port is clk and the reset port is reset.
- Reset: state=IDLE and count=0 at the next edge. All outputs are 0 in IDLE, busy included. Reset overrides everything, including mid-operation; the datapath contents are then don't-care.
- States: IDLE, LOAD, TEST, ADD, SHIFT, DONE. Outputs are Moore decodes of the state; no combinational path from q0 or start to any output.
- IDLE: start=1 -> LOAD; else stay in IDLE.
- LOAD: ld_operands=1, clr_acc=1, busy=1; count<=0 -> TEST.
- TEST: busy=1 only. q0=1 -> ADD; q0=0 -> SHIFT.
- ADD: add_en=1, busy=1 -> SHIFT.
- SHIFT: shift_en=1, busy=1; count<=count+1. If count==N-1 (pre-increment value) -> DONE; else -> TEST.
- DONE: done=1, busy=1; count holds N -> IDLE.
- Per-bit cost: 2 cycles (q0=0) or 3 cycles (q0=1).
- Total from the start-sampling edge to the DONE cycle: 1 + sum over bits of (2+q0_i) + 1 cycles.
- start while busy (LOAD through DONE) is ignored; no queuing. A start held high through DONE begins a new operation from IDLE on the following edge.
- At most one of ld_operands, add_en, shift_en is high in any cycle. clr_acc is high only together with ld_operands.
- count is unsigned and never wraps, since max = N < 2^CW. It is held in IDLE until the next LOAD clears it.
- q0 is ignored outside TEST.

Test Plan:
- Reset check: assert reset for 2 cycles while in ADD mid-operation -> next cycle state=IDLE, count=0, busy=0, all enables 0.
- Multiplier 0x0000, N=16: start sampled at edge 0 -> LOAD in cycle 1; 16 TEST/SHIFT pairs in cycles 2..33 with add_en never high; done=1 in cycle 34 with count=16; busy=0 in cycle 35.
- Multiplier 0xFFFF: 16 TEST/ADD/SHIFT triples -> exactly 16 add_en pulses and 16 shift_en pulses; done in cycle 50.
- Multiplier 0x0005 with a datapath model, multiplicand 0x0003: add_en high only for bits 0 and 2; product 0x0000000F at done; done in cycle 36.
- start pulsed in TEST and again in DONE -> ignored, exactly one done pulse. start held high continuously -> back-to-back operations separated by exactly one IDLE cycle.
- Assertion run, random multipliers, 1000 operations: one-hot enables held every cycle; done exactly once per start accepted; count==N at every done.
